linked_machine_scheduler: RTL

Sequencer for the two linked slave counter machines. It turns button presses into one controlled run of slave 1 or slave 2: clear the slave, enable it, watch for its terminal state, then report done or timeout. It replaces ad-hoc button decoding in the linked-machine top level. Slave outputs are in the CLK domain; buttons are asynchronous.

---
 rtl/linked_machine_scheduler_pkg.sv | 50 +++++
 rtl/linked_machine_scheduler_button_sync_edge.sv | 35 +++
 rtl/linked_machine_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/linked_machine_scheduler_pkg.sv
// +-------------------------------------------------------------------------+
// | linked_machine_scheduler_pkg                                            |
// | Shared state encoding and status codes for the linked-machine scheduler.|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package linked_machine_scheduler_pkg;

  localparam logic [6:0] IDLE  = 7'b000_0001;
  localparam logic [6:0] CLR1  = 7'b000_0010;
  localparam logic [6:0] CLR2  = 7'b000_0100;
  localparam logic [6:0] RUN1  = 7'b000_1000;
  localparam logic [6:0] RUN2  = 7'b001_0000;
  localparam logic [6:0] DONE  = 7'b010_0000;
  localparam logic [6:0] FAULT = 7'b100_0000;

  typedef enum logic [6:0] {
    ST_IDLE  = IDLE,
    ST_CLR1  = CLR1,
    ST_CLR2  = CLR2,
    ST_RUN1  = RUN1,
    ST_RUN2  = RUN2,
    ST_DONE  = DONE,
    ST_FAULT = FAULT
  } state_t;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_S1   = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;
  localparam logic [1:0] MC_S2   = 2'd3;

  localparam logic [3:0] DEF_TERM1 = 4'b0111;
  localparam logic [3:0] DEF_TERM2 = 4'b1000;

  function automatic logic [1:0] mc_code(input state_t s);
    logic [1:0] code;
    code = MC_IDLE;
    case (s)
      ST_CLR1, ST_RUN1:  code = MC_S1;
      ST_CLR2, ST_RUN2:  code = MC_S2;
      ST_DONE, ST_FAULT: code = MC_DONE;
      default:           code = MC_IDLE;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/linked_machine_scheduler_button_sync_edge.sv
// +-------------------------------------------------------------------------+
// | button_sync_edge                                                        |
// | Two-flop synchroniser with history flop; EDGE marks a rising press.     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module button_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic EDGE
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= BTN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign EDGE = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/linked_machine_scheduler.sv
// +-------------------------------------------------------------------------+
// | linked_machine_scheduler                                                |
// | Runs slave 1 or slave 2 once per button press: clear, enable, watch.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module linked_machine_scheduler
  import linked_machine_scheduler_pkg::*;
#(
  parameter logic [3:0] TERM1          = DEF_TERM1,
  parameter logic [3:0] TERM2          = DEF_TERM2,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_LEFT,
  input  logic       BTN_CENTRE,
  input  logic       BTN_RIGHT,
  input  logic [3:0] STATE_OUT1,
  input  logic [3:0] STATE_OUT2,
  output logic       ENABLE1,
  output logic       ENABLE2,
  output logic       CLEAR1,
  output logic       CLEAR2,
  output logic [1:0] MASTER_CONTROL,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAULT
);

  localparam int                  c_timer_w   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_timer_w-1:0] c_timer_max = c_timer_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);

  logic w_edge_left;
  logic w_edge_centre;
  logic w_edge_right;

  button_sync_edge u_sync_left (
    .CLK   (CLK),
    .RESET (RESET),
    .BTN   (BTN_LEFT),
    .EDGE  (w_edge_left)
  );

  button_sync_edge u_sync_centre (
    .CLK   (CLK),
    .RESET (RESET),
    .BTN   (BTN_CENTRE),
    .EDGE  (w_edge_centre)
  );

  button_sync_edge u_sync_right (
    .CLK   (CLK),
    .RESET (RESET),
    .BTN   (BTN_RIGHT),
    .EDGE  (w_edge_right)
  );

  // One event per cycle: lower-priority buttons are dropped, not queued.
  logic w_ev_right;
  logic w_ev_centre;
  logic w_ev_left;

  assign w_ev_right  = w_edge_right;
  assign w_ev_centre = w_edge_centre & ~w_edge_right;
  assign w_ev_left   = w_edge_left & ~w_edge_centre & ~w_edge_right;

  state_t                r_state;
  state_t                w_next;
  logic [c_timer_w-1:0]  r_timer;
  logic                  r_was_done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_was_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_was_done <= (r_state == ST_DONE);
      if (r_state == ST_CLR1 || r_state == ST_CLR2) begin
        r_timer <= '0;
      end else if ((r_state == ST_RUN1 || r_state == ST_RUN2) && r_timer != c_timer_max) begin
        r_timer <= r_timer + c_timer_one;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    ENABLE1        = 1'b0;
    ENABLE2        = 1'b0;
    CLEAR1         = 1'b0;
    CLEAR2         = 1'b0;
    BUSY           = 1'b0;
    DONE           = 1'b0;
    FAULT          = 1'b0;
    MASTER_CONTROL = mc_code(r_state);

    case (r_state)
      ST_IDLE: begin
        if (w_ev_right)       w_next = ST_CLR1;
        else if (w_ev_centre) w_next = ST_DONE;
        else if (w_ev_left)   w_next = ST_CLR2;
      end
      ST_CLR1: begin
        CLEAR1 = 1'b1;
        BUSY   = 1'b1;
        w_next = ST_RUN1;
      end
      ST_CLR2: begin
        CLEAR2 = 1'b1;
        BUSY   = 1'b1;
        w_next = ST_RUN2;
      end
      ST_RUN1: begin
        ENABLE1 = 1'b1;
        BUSY    = 1'b1;
        if (STATE_OUT1 == TERM1)        w_next = ST_DONE;
        else if (w_ev_centre)           w_next = ST_IDLE;
        else if (r_timer == c_timer_max) w_next = ST_FAULT;
      end
      ST_RUN2: begin
        ENABLE2 = 1'b1;
        BUSY    = 1'b1;
        if (STATE_OUT2 == TERM2)        w_next = ST_DONE;
        else if (w_ev_centre)           w_next = ST_IDLE;
        else if (r_timer == c_timer_max) w_next = ST_FAULT;
      end
      ST_DONE: begin
        DONE = ~r_was_done;
        if (w_ev_centre) w_next = ST_IDLE;
      end
      ST_FAULT: begin
        FAULT = 1'b1;
        if (w_ev_centre) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
